// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: IDLE/FETCH FSM feeding a 2-entry {pc, op} FIFO.
// Optional delivered-instruction counter enabled by macro FETCH_PERF_CNT_EN.
module fetch_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  output logic [7:0]  pc,
  input  logic [15:0] op,
  input  logic        redirect_valid,
  input  logic [7:0]  redirect_pc,
  output logic        inst_valid,
  output logic [15:0] inst,
  output logic [7:0]  inst_pc,
  input  logic        inst_ready,
  output logic [15:0] fetch_cnt
);

  typedef enum logic {IDLE, FETCH} state_t;

  state_t      state, state_nxt;
  logic [1:0]  count;
  logic [15:0] tail_op;
  logic [7:0]  tail_pc;
  logic        push, pop;

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    push      = 1'b0;
    case (state)
      IDLE:    if (run)  state_nxt = FETCH;
      FETCH:   if (!run) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    pop  = (count != 2'd0) && inst_ready && !redirect_valid;
    push = (state == FETCH) && run && !redirect_valid && ((count != 2'd2) || pop);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // The head entry doubles as the inst/inst_pc output register, so it simply
  // keeps its last value whenever the FIFO drains or is flushed.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc      <= '0;
      count   <= '0;
      inst    <= '0;
      inst_pc <= '0;
      tail_op <= '0;
      tail_pc <= '0;
    end else if (redirect_valid) begin
      pc    <= redirect_pc;
      count <= '0;
    end else begin
      if (push) pc <= pc + 8'd1;
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) begin
            inst    <= op;
            inst_pc <= pc;
          end else begin
            tail_op <= op;
            tail_pc <= pc;
          end
          count <= count + 2'd1;
        end
        2'b01: begin
          if (count == 2'd2) begin
            inst    <= tail_op;
            inst_pc <= tail_pc;
          end
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            inst    <= op;
            inst_pc <= pc;
          end else begin
            inst    <= tail_op;
            inst_pc <= tail_pc;
            tail_op <= op;
            tail_pc <= pc;
          end
        end
        default: ;
      endcase
    end
  end

  assign inst_valid = (count != 2'd0);

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] perf_cnt;

  always_ff @(posedge clk) begin
    if (rst)                       perf_cnt <= '0;
    else if (pop && perf_cnt != '1) perf_cnt <= perf_cnt + 16'd1;
  end

  assign fetch_cnt = perf_cnt;
`else
  assign fetch_cnt = '0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed self-checking bench for fetch_ctrl with a combinational instruction memory model.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst, run, redirect_valid, inst_ready;
  logic [7:0]  pc, redirect_pc, inst_pc;
  logic [15:0] op, inst, fetch_cnt;
  logic        inst_valid;

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;
  int unsigned pops   = 0;

  always #5 clk = ~clk;

  function automatic logic [15:0] mem(input logic [7:0] a);
    return {a ^ 8'h5A, a};
  endfunction

  assign op = mem(pc);

  fetch_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .run            (run),
    .pc             (pc),
    .op             (op),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_ready     (inst_ready),
    .fetch_cnt      (fetch_cnt)
  );

  // Expected pop count is derived from the handshake seen just before each edge.
  task automatic step();
    if (rst) pops = 0;
    else if (inst_valid && inst_ready && !redirect_valid && pops < 32'hFFFF) pops++;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_head(input string tag, input logic [7:0] a);
    chk({tag, "_valid"}, {15'd0, inst_valid}, 16'd1);
    chk({tag, "_pc"}, {8'd0, inst_pc}, {8'd0, a});
    chk({tag, "_inst"}, inst, mem(a));
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
    step(); step();
    chk("rst_valid", {15'd0, inst_valid}, 16'd0);
    chk("rst_pc", {8'd0, pc}, 16'd0);
    chk("rst_inst", inst, 16'd0);
    chk("rst_inst_pc", {8'd0, inst_pc}, 16'd0);
    chk("rst_cnt", fetch_cnt, 16'd0);

    // Stream
    rst = 1'b0; run = 1'b1; inst_ready = 1'b1;
    step();
    chk("stream_first_edge", {15'd0, inst_valid}, 16'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk_head("stream", 8'(i));
    end

    // Backpressure from a fresh start
    rst = 1'b1; step();
    rst = 1'b0; inst_ready = 1'b0;
    step();
    for (int i = 0; i < 5; i++) step();
    chk("bp_pc", {8'd0, pc}, 16'd2);
    chk_head("bp_hold", 8'd0);
    inst_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      step();
      chk_head("bp_drain", 8'(i));
    end

    // Redirect while full
    redirect_valid = 1'b1; redirect_pc = 8'd20;
    step();
    chk("redir_flush", {15'd0, inst_valid}, 16'd0);
    chk("redir_pc", {8'd0, pc}, 16'd20);
    redirect_valid = 1'b0;
    for (int i = 20; i < 23; i++) begin
      step();
      chk_head("redir", 8'(i));
    end

    // Wrap
    redirect_valid = 1'b1; redirect_pc = 8'hFE;
    step();
    redirect_valid = 1'b0;
    chk("wrap_flush", {15'd0, inst_valid}, 16'd0);
    step(); chk_head("wrap_fe", 8'hFE);
    step(); chk_head("wrap_ff", 8'hFF);
    step(); chk_head("wrap_00", 8'h00);
    step(); chk_head("wrap_01", 8'h01);

    // Fill to two entries, then reset mid-run with every other input asserted
    inst_ready = 1'b0;
    step(); step();
    chk("full_pc", {8'd0, pc}, 16'd3);
    chk_head("full_hold", 8'h01);
    chk("cnt_before_rst", fetch_cnt,
`ifdef FETCH_PERF_CNT_EN
        16'(pops)
`else
        16'd0
`endif
    );
    rst = 1'b1; inst_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 8'h77;
    step();
    chk("mid_rst_valid", {15'd0, inst_valid}, 16'd0);
    chk("mid_rst_pc", {8'd0, pc}, 16'd0);
    chk("mid_rst_inst", inst, 16'd0);
    chk("mid_rst_cnt", fetch_cnt, 16'd0);
    rst = 1'b0; redirect_valid = 1'b0;
    step();
    chk("restart_idle", {15'd0, inst_valid}, 16'd0);
    step();
    chk_head("restart", 8'h00);

    // Drain with run low: head keeps its last value once empty
    run = 1'b0;
    step();
    chk("drain_valid", {15'd0, inst_valid}, 16'd0);
    chk("drain_hold_pc", {8'd0, inst_pc}, 16'd0);
    chk("drain_hold_inst", inst, mem(8'h00));
    chk("drain_pc", {8'd0, pc}, 16'd1);
    step();
    chk("idle_no_push", {15'd0, inst_valid}, 16'd0);

`ifdef FETCH_PERF_CNT_EN
    chk("cnt_pops", fetch_cnt, 16'(pops));
    force dut.perf_cnt = 16'hFFFE;
    #1;
    release dut.perf_cnt;
    run = 1'b1; inst_ready = 1'b1;
    for (int i = 0; i < 5; i++) step();
    chk("cnt_sat", fetch_cnt, 16'hFFFF);
`else
    chk("cnt_off", fetch_cnt, 16'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 The block SHALL have port run, input, 1 bit: fetch enable; 1 = fetch, 0 = stop fetching.
REQ-004 The block SHALL have port pc, output, 8 bits: instruction address driven to the combinational instruction memory.
REQ-005 The block SHALL have port op, input, 16 bits: instruction word returned by the instruction memory for pc in the same cycle.
REQ-006 The block SHALL have port redirect_valid, input, 1 bit: branch/jump redirect request.
REQ-007 The block SHALL have port redirect_pc, input, 8 bits: redirect target address.
REQ-008 The block SHALL have port inst_valid, output, 1 bit: head instruction available to decode.
REQ-009 The block SHALL have port inst, output, 16 bits: head instruction word.
REQ-010 The block SHALL have port inst_pc, output, 8 bits: address of the head instruction.
REQ-011 The block SHALL have port inst_ready, input, 1 bit: decode accepts the head this cycle.
REQ-012 The block SHALL have port fetch_cnt, output, 16 bits: delivered-instruction count (see Configuration).

Function
REQ-013 The block SHALL implement two states: IDLE and FETCH.
REQ-014 In IDLE, run=1 SHALL move the state to FETCH at the next edge, with no push on that edge.
REQ-015 In FETCH, run=0 SHALL move the state to IDLE at the next edge, with no push on that edge.
REQ-016 The block SHALL contain a 2-entry FIFO of {pc, op} pairs; count is 0..2.
REQ-017 Pop SHALL occur when inst_valid=1 and inst_ready=1.
REQ-018 Push: in FETCH with run=1, at each edge where count<2 or a pop occurs, {pc, op} SHALL be written and pc SHALL increment by 1.
REQ-019 A simultaneous push and pop SHALL leave count unchanged; the FIFO SHALL never overflow or underflow.
REQ-020 pc SHALL wrap from 8'hFF to 8'h00 on increment.
REQ-021 inst_valid SHALL be 1 exactly when count!=0; inst and inst_pc SHALL be the oldest entry, registered (zero combinational paths from op).
REQ-022 Latency: an instruction pushed at edge N SHALL appear on inst/inst_valid after edge N when the FIFO was empty.
REQ-023 redirect_valid=1 in any state SHALL, at the next edge: flush the FIFO (count=0), load pc=redirect_pc, suppress push and pop.
REQ-024 redirect_valid SHALL take priority over push, pop and state changes; the state SHALL update per run as normal.
REQ-025 After a redirect in FETCH with run=1, the target instruction SHALL be valid after the following edge.
REQ-026 When inst_valid=0, inst and inst_pc SHALL hold their last values.

Reset
REQ-027 rst=1 SHALL at the edge set state=IDLE, pc=0, count=0, inst_valid=0, inst=16'h0000, inst_pc=8'h00 and fetch_cnt=0.
REQ-028 rst SHALL override run, redirect_valid and inst_ready, including mid-operation with a full FIFO.

Configuration
REQ-029 With macro FETCH_PERF_CNT_EN defined, fetch_cnt SHALL increment by 1 on every pop and saturate at 16'hFFFF.
REQ-030 Without FETCH_PERF_CNT_EN, fetch_cnt SHALL be constant 0 and no counter logic SHALL exist.

Verification
REQ-031 Stream: reset, run=1, inst_ready=1 -> inst_pc sequence 0,1,2,3 on consecutive cycles starting 2 edges after run rises; inst equals memory contents.
REQ-032 Backpressure: inst_ready=0 for 5 cycles -> count stops at 2, pc holds at 2, inst_pc stays 0; on ready=1, no entry is lost or duplicated.
REQ-033 Redirect: redirect_valid=1 with redirect_pc=20 while FIFO is full -> FIFO flushed; next valid inst_pc=20, then 21, 22.
REQ-034 Wrap: redirect to 8'hFE -> inst_pc sequence FE, FF, 00, 01.
REQ-035 Reset mid-run: rst=1 with count=2 -> next cycle inst_valid=0, pc=0, state IDLE; run=1 restarts from address 0.
REQ-036 With FETCH_PERF_CNT_EN: after 10 pops fetch_cnt=10; with the counter preloaded to FFFE by 3 pops via force, it reads FFFF; without the macro it reads 0.
